// File: rtl/id_exe_hazard_reg.sv
// id_exe_hazard_reg
//   ID/EXE pipeline register with load-use hazard detection, bubble
//   insertion on a load-use stall or a branch flush, and saturating
//   stall/flush cycle counters.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   IF_IDRegrs1/rs2/rd       register fields of the instruction in decode
//   ID_UsesRs1/Rs2           decode actually reads rs1/rs2
//   ID_Ctrl                  {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0]}
//   ID_RD1/RD2/Imm/PC        operands, immediate and PC from decode
//   EXE_Flush                taken branch/jump in execute, kill decode
//   ID_EXE*                  registered copies of the above (to execute/forwarding)
//   PCWrite, IF_IDWrite      0 = hold PC / IF/ID this cycle
//   StallCount, FlushCount   saturating counts of stall and flush cycles
module id_exe_hazard_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_IDRegrs1,
    input  logic [4:0]       IF_IDRegrs2,
    input  logic [4:0]       IF_IDRegrd,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic [7:0]       ID_Ctrl,
    input  logic [XLEN-1:0]  ID_RD1,
    input  logic [XLEN-1:0]  ID_RD2,
    input  logic [XLEN-1:0]  ID_Imm,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic             EXE_Flush,
    output logic [4:0]       ID_EXERegrs1,
    output logic [4:0]       ID_EXERegrs2,
    output logic [4:0]       ID_EXERegrd,
    output logic [7:0]       ID_EXE_Ctrl,
    output logic [XLEN-1:0]  ID_EXE_RD1,
    output logic [XLEN-1:0]  ID_EXE_RD2,
    output logic [XLEN-1:0]  ID_EXE_Imm,
    output logic [XLEN-1:0]  ID_EXE_PC,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic hz;
    logic stall;
    logic bubble;

    // A load in EXE whose rd is read by decode; x0 never hazards, and a
    // bubble (Ctrl=0, rd=0) can never hazard either.
    assign hz = ID_EXE_Ctrl[6] && (ID_EXERegrd != 5'd0) &&
                ((ID_UsesRs1 && (IF_IDRegrs1 == ID_EXERegrd)) ||
                 (ID_UsesRs2 && (IF_IDRegrs2 == ID_EXERegrd)));

    // Flush and reset both override the stall: the fetch unit must be
    // allowed to redirect or restart.
    assign stall      = hz && !EXE_Flush && !rst;
    assign bubble     = EXE_Flush || hz;
    assign PCWrite    = !stall;
    assign IF_IDWrite = !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ID_EXERegrs1 <= '0;
            ID_EXERegrs2 <= '0;
            ID_EXERegrd  <= '0;
            ID_EXE_Ctrl  <= '0;
            ID_EXE_RD1   <= '0;
            ID_EXE_RD2   <= '0;
            ID_EXE_Imm   <= '0;
            ID_EXE_PC    <= '0;
            StallCount   <= '0;
            FlushCount   <= '0;
        end else begin
            if (bubble) begin
                ID_EXERegrs1 <= '0;
                ID_EXERegrs2 <= '0;
                ID_EXERegrd  <= '0;
                ID_EXE_Ctrl  <= '0;
                ID_EXE_RD1   <= '0;
                ID_EXE_RD2   <= '0;
                ID_EXE_Imm   <= '0;
                ID_EXE_PC    <= '0;
            end else begin
                ID_EXERegrs1 <= IF_IDRegrs1;
                ID_EXERegrs2 <= IF_IDRegrs2;
                ID_EXERegrd  <= IF_IDRegrd;
                ID_EXE_Ctrl  <= ID_Ctrl;
                ID_EXE_RD1   <= ID_RD1;
                ID_EXE_RD2   <= ID_RD2;
                ID_EXE_Imm   <= ID_Imm;
                ID_EXE_PC    <= ID_PC;
            end
            // Flush wins over a simultaneous hazard: only one counter moves.
            if (EXE_Flush) begin
                if (FlushCount != CNT_MAX) FlushCount <= FlushCount + CNT_ONE;
            end else if (hz) begin
                if (StallCount != CNT_MAX) StallCount <= StallCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
module tb_id_exe_hazard_reg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam logic [7:0] LW  = 8'b1101_1000;
    localparam logic [7:0] ADD = 8'b1000_0010;

    logic clk = 0, rst = 1;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic u1 = 0, u2 = 0, flush = 0;
    logic [7:0] ctrl = 0;
    logic [XLEN-1:0] rd1 = 0, rd2 = 0, imm = 0, pc = 0;
    logic [4:0] o_rs1, o_rs2, o_rd;
    logic [7:0] o_ctrl;
    logic [XLEN-1:0] o_rd1, o_rd2, o_imm, o_pc;
    logic pcw, ifw;
    logic [CNT_W-1:0] scnt, fcnt;

    int n_checks = 0, n_err = 0;

    // reference model: what the EXE stage should hold
    logic [4:0] m_rs1, m_rs2, m_rd;
    logic [7:0] m_ctrl;
    logic [XLEN-1:0] m_rd1, m_rd2, m_imm, m_pc;
    logic m_dvalid;
    int m_stall, m_flush;

    id_exe_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IF_IDRegrs1(rs1), .IF_IDRegrs2(rs2), .IF_IDRegrd(rd),
        .ID_UsesRs1(u1), .ID_UsesRs2(u2), .ID_Ctrl(ctrl),
        .ID_RD1(rd1), .ID_RD2(rd2), .ID_Imm(imm), .ID_PC(pc),
        .EXE_Flush(flush),
        .ID_EXERegrs1(o_rs1), .ID_EXERegrs2(o_rs2), .ID_EXERegrd(o_rd),
        .ID_EXE_Ctrl(o_ctrl), .ID_EXE_RD1(o_rd1), .ID_EXE_RD2(o_rd2),
        .ID_EXE_Imm(o_imm), .ID_EXE_PC(o_pc),
        .PCWrite(pcw), .IF_IDWrite(ifw),
        .StallCount(scnt), .FlushCount(fcnt)
    );

    always #5 clk = ~clk;

    // a load sitting in EXE whose rd is read by the instruction in decode
    function automatic bit model_hz();
        bit r1, r2;
        r1 = (u1 === 1'b1) && (rs1 == m_rd);
        r2 = (u2 === 1'b1) && (rs2 == m_rd);
        return (m_ctrl[6] === 1'b1) && (m_rd != 0) && (r1 || r2);
    endfunction

    function automatic bit model_pcw();
        return rst || flush || !model_hz();
    endfunction

    task automatic model_update();
        if (rst) begin
            {m_rs1, m_rs2, m_rd, m_ctrl} = '0;
            {m_rd1, m_rd2, m_imm, m_pc} = '0;
            m_dvalid = 1; m_stall = 0; m_flush = 0;
        end else if (flush || model_hz()) begin
            if (flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            else       m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            {m_rs1, m_rs2, m_rd, m_ctrl} = '0;
            m_dvalid = 0;
        end else begin
            m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_ctrl = ctrl;
            m_rd1 = rd1; m_rd2 = rd2; m_imm = imm; m_pc = pc;
            m_dvalid = 1;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic ua, input logic ub, input logic [7:0] c, input logic f);
        rs1 = a; rs2 = b; rd = d; u1 = ua; u2 = ub; ctrl = c; flush = f;
        rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom;
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            set_in(5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 8'($urandom), 0);
            n_checks++;
            if ({pcw, ifw} !== 2'b11) begin
                n_err++; $display("FAIL reset_pcw got=%b want=11", {pcw, ifw});
            end
            tick();
            n_checks++;
            if ({o_rs1, o_rs2, o_rd, o_ctrl, o_rd1, o_rd2, o_imm, o_pc, scnt, fcnt} !== '0) begin
                n_err++;
                $display("FAIL reset_regs got rs1=%0d rs2=%0d rd=%0d ctrl=%h pc=%h s=%0d f=%0d want all 0",
                         o_rs1, o_rs2, o_rd, o_ctrl, o_pc, scnt, fcnt);
            end
        end
        rst = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 2, 5, 1, 1, LW, 0);
        tick();
        set_in(5, 6, 8, 1, 1, ADD, 0);
        n_checks++;
        if ({pcw, ifw} !== 2'b00) begin
            n_err++; $display("FAIL lu_stall_pcw got=%b want=00", {pcw, ifw});
        end
        tick();
        n_checks++;
        if (o_ctrl !== 8'h00 || o_rd !== 5'd0 || int'(scnt) != 1) begin
            n_err++; $display("FAIL lu_bubble got ctrl=%h rd=%0d stall=%0d want 00/0/1", o_ctrl, o_rd, scnt);
        end
        n_checks++;
        if ({pcw, ifw} !== 2'b11) begin
            n_err++; $display("FAIL lu_release_pcw got=%b want=11", {pcw, ifw});
        end
        tick();
        n_checks++;
        if (o_rs1 !== 5'd5 || o_ctrl !== ADD || o_rd !== 5'd8 || o_pc !== pc || int'(scnt) != 1) begin
            n_err++;
            $display("FAIL lu_capture got rs1=%0d ctrl=%h rd=%0d stall=%0d want 5/%h/8/1", o_rs1, o_ctrl, o_rd, scnt, ADD);
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_in(3, 4, 0, 1, 1, LW, 0);
        tick();
        set_in(0, 0, 9, 1, 1, ADD, 0);
        n_checks++;
        if ({pcw, ifw} !== 2'b11) begin
            n_err++; $display("FAIL x0_pcw got=%b want=11", {pcw, ifw});
        end
        tick();
        n_checks++;
        if (o_ctrl !== ADD || o_rd !== 5'd9 || o_imm !== imm || int'(scnt) != 0) begin
            n_err++; $display("FAIL x0_capture got ctrl=%h rd=%0d stall=%0d want %h/9/0", o_ctrl, o_rd, scnt, ADD);
        end
    endtask

    task automatic test_uses_flag();
        do_reset();
        set_in(1, 1, 7, 1, 1, LW, 0);
        tick();
        set_in(1, 7, 10, 1, 0, ADD, 0);
        n_checks++;
        if (pcw !== 1'b1) begin
            n_err++; $display("FAIL uses0_pcw got=%b want=1", pcw);
        end
        tick();
        set_in(1, 1, 7, 1, 1, LW, 0);
        tick();
        set_in(1, 7, 10, 1, 1, ADD, 0);
        n_checks++;
        if ({pcw, ifw} !== 2'b00) begin
            n_err++; $display("FAIL uses1_pcw got=%b want=00", {pcw, ifw});
        end
        tick();
        n_checks++;
        if (int'(scnt) != 1 || o_ctrl !== 8'h00) begin
            n_err++; $display("FAIL uses1_count got stall=%0d ctrl=%h want 1/00", scnt, o_ctrl);
        end
    endtask

    task automatic test_flush_wins();
        do_reset();
        set_in(1, 2, 5, 1, 1, LW, 0);
        tick();
        set_in(5, 5, 6, 1, 1, ADD, 1);
        n_checks++;
        if ({pcw, ifw} !== 2'b11) begin
            n_err++; $display("FAIL flush_pcw got=%b want=11", {pcw, ifw});
        end
        tick();
        n_checks++;
        if (o_ctrl !== 8'h00 || {o_rs1, o_rs2, o_rd} !== 15'd0 || int'(fcnt) != 1 || int'(scnt) != 0) begin
            n_err++;
            $display("FAIL flush_bubble got ctrl=%h rs1=%0d flush=%0d stall=%0d want 00/0/1/0", o_ctrl, o_rs1, fcnt, scnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 3, 0, 0, LW, 0);
            tick();
            set_in(3, 0, 4, 1, 0, ADD, 0);
            tick();
        end
        n_checks++;
        if (int'(scnt) != CMAX) begin
            n_err++; $display("FAIL sat_stall got=%0d want=%0d", scnt, CMAX);
        end
        // reset arrives while the stall would be taken
        set_in(0, 0, 3, 0, 0, LW, 0);
        tick();
        rst = 1;
        set_in(3, 0, 4, 1, 0, ADD, 0);
        n_checks++;
        if ({pcw, ifw} !== 2'b11) begin
            n_err++; $display("FAIL rst_stall_pcw got=%b want=11", {pcw, ifw});
        end
        tick();
        rst = 0;
        n_checks++;
        if ({o_rs1, o_rs2, o_rd, o_ctrl, o_rd1, o_rd2, o_imm, o_pc, scnt, fcnt} !== '0) begin
            n_err++; $display("FAIL rst_stall_regs got ctrl=%h rd=%0d s=%0d want all 0", o_ctrl, o_rd, scnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), {1'($urandom), 1'($urandom_range(0, 1)), 6'($urandom)},
                   ($urandom_range(0, 7) == 0));
            n_checks++;
            if ({pcw, ifw} !== {2{model_pcw()}}) begin
                n_err++; $display("FAIL rnd_pcw cyc=%0d got=%b want=%b", i, {pcw, ifw}, {2{model_pcw()}});
            end
            tick();
            n_checks++;
            if ({o_rs1, o_rs2, o_rd, o_ctrl} !== {m_rs1, m_rs2, m_rd, m_ctrl}) begin
                n_err++;
                $display("FAIL rnd_ctrl cyc=%0d got=%h/%0d/%0d/%0d want=%h/%0d/%0d/%0d",
                         i, o_ctrl, o_rs1, o_rs2, o_rd, m_ctrl, m_rs1, m_rs2, m_rd);
            end
            if (m_dvalid) begin
                n_checks++;
                if ({o_rd1, o_rd2, o_imm, o_pc} !== {m_rd1, m_rd2, m_imm, m_pc}) begin
                    n_err++; $display("FAIL rnd_data cyc=%0d got pc=%h want pc=%h", i, o_pc, m_pc);
                end
            end
            n_checks++;
            if (int'(scnt) != m_stall || int'(fcnt) != m_flush) begin
                n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, scnt, fcnt, m_stall, m_flush);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_uses_flag();
        test_flush_wins();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
